ppu_dispatch: RTL



---
 rtl/ppu_dispatch_if.sv | 53 +++++
 rtl/ppu_dispatch.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ppu_dispatch_if.sv
// rtl/ppu_dispatch_if.sv - host request, core and result signals of the posit dispatcher
interface ppu_dispatch_if #(
    parameter int N        = 16,
    parameter int OP_BITS  = 3,
    parameter int TAG_BITS = 4
);
    logic                in_valid_i;
    logic                in_ready_o;
    logic [N-1:0]        in_p1_i;
    logic [N-1:0]        in_p2_i;
    logic [N-1:0]        in_p3_i;
    logic [OP_BITS-1:0]  in_op_i;
    logic [TAG_BITS-1:0] in_tag_i;

    logic [N-1:0]        core_p1_o;
    logic [N-1:0]        core_p2_o;
    logic [N-1:0]        core_p3_o;
    logic [OP_BITS-1:0]  core_op_o;
    logic                core_stall_o;
    logic [N-1:0]        core_pout_i;
    logic [OP_BITS-1:0]  core_op_i;

    logic                out_valid_o;
    logic                out_ready_i;
    logic [N-1:0]        out_pout_o;
    logic [OP_BITS-1:0]  out_op_o;
    logic [TAG_BITS-1:0] out_tag_o;

    logic                busy_o;
    logic                err_o;

    // Dispatcher side
    modport slave (
        input  in_valid_i, in_p1_i, in_p2_i, in_p3_i, in_op_i, in_tag_i,
        output in_ready_o,
        output core_p1_o, core_p2_o, core_p3_o, core_op_o, core_stall_o,
        input  core_pout_i, core_op_i,
        output out_valid_o, out_pout_o, out_op_o, out_tag_o,
        input  out_ready_i,
        output busy_o, err_o
    );

    // Host and core side
    modport master (
        output in_valid_i, in_p1_i, in_p2_i, in_p3_i, in_op_i, in_tag_i,
        input  in_ready_o,
        input  core_p1_o, core_p2_o, core_p3_o, core_op_o, core_stall_o,
        output core_pout_i, core_op_i,
        input  out_valid_o, out_pout_o, out_op_o, out_tag_o,
        output out_ready_i,
        input  busy_o, err_o
    );
endinterface

// File: rtl/ppu_dispatch.sv
// rtl/ppu_dispatch.sv - credit-based dispatcher around a fixed-latency posit core with in-order result FIFO
module ppu_dispatch #(
    parameter int N          = 16,
    parameter int OP_BITS    = 3,
    parameter int TAG_BITS   = 4,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst,
    ppu_dispatch_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_SUM  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DEPTH_FULL = CW'(FIFO_DEPTH);

    logic                issue;
    logic                in_ready;
    logic                cap_valid;
    logic [OP_BITS-1:0]  cap_op;
    logic [TAG_BITS-1:0] cap_tag;
    logic                push;
    logic                pop;
    logic                out_valid;

    logic [N-1:0]        mem_pout [FIFO_DEPTH];
    logic [OP_BITS-1:0]  mem_op   [FIFO_DEPTH];
    logic [TAG_BITS-1:0] mem_tag  [FIFO_DEPTH];
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       inflight_count;
    logic [CW:0]         credit_used;
    logic                err_q;

    // Credit uses registered counts only, so a pop never reaches in_ready combinationally.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight_count};
    assign in_ready    = !rst && (credit_used < DEPTH_SUM);
    assign issue       = bus.in_valid_i && in_ready;

    assign bus.core_p1_o    = bus.in_p1_i;
    assign bus.core_p2_o    = bus.in_p2_i;
    assign bus.core_p3_o    = bus.in_p3_i;
    assign bus.core_op_o    = bus.in_op_i;
    assign bus.core_stall_o = 1'b0;

    generate
        if (LATENCY == 0) begin : g_comb
            assign cap_valid = issue;
            assign cap_op    = bus.in_op_i;
            assign cap_tag   = bus.in_tag_i;
        end else begin : g_pipe
            logic [LATENCY-1:0]  trk_valid;
            logic [OP_BITS-1:0]  trk_op  [LATENCY];
            logic [TAG_BITS-1:0] trk_tag [LATENCY];

            always_ff @(posedge clk_i) begin
                if (rst) begin
                    trk_valid <= '0;
                end else begin
                    trk_valid[0] <= issue;
                    for (int i = 1; i < LATENCY; i++) begin
                        trk_valid[i] <= trk_valid[i-1];
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                trk_op[0]  <= bus.in_op_i;
                trk_tag[0] <= bus.in_tag_i;
                for (int i = 1; i < LATENCY; i++) begin
                    trk_op[i]  <= trk_op[i-1];
                    trk_tag[i] <= trk_tag[i-1];
                end
            end

            assign cap_valid = trk_valid[LATENCY-1];
            assign cap_op    = trk_op[LATENCY-1];
            assign cap_tag   = trk_tag[LATENCY-1];
        end
    endgenerate

    assign push      = cap_valid;
    assign out_valid = !rst && (fifo_count != '0);
    assign pop       = out_valid && bus.out_ready_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pout[wptr] <= bus.core_pout_i;
            mem_op[wptr]   <= cap_op;
            mem_tag[wptr]  <= cap_tag;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            wptr           <= '0;
            rptr           <= '0;
            fifo_count     <= '0;
            inflight_count <= '0;
            err_q          <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            case ({issue, cap_valid})
                2'b10:   inflight_count <= inflight_count + 1'b1;
                2'b01:   inflight_count <= inflight_count - 1'b1;
                default: inflight_count <= inflight_count;
            endcase
            if (push && (bus.core_op_i != cap_op)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            assert (!(push && !pop && (fifo_count == DEPTH_FULL)));
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_pout_o  = rst ? '0 : mem_pout[rptr];
    assign bus.out_op_o    = rst ? '0 : mem_op[rptr];
    assign bus.out_tag_o   = rst ? '0 : mem_tag[rptr];
    assign bus.busy_o      = !rst && ((inflight_count != '0) || (fifo_count != '0));
    assign bus.err_o       = !rst && err_q;
endmodule
